// File: rtl/accu_mc.sv
// accu_mc: CHANNELS independent ACC_W-bit accumulators driven by ADD/SUB/LOAD/CLEAR ops, each op wrapping or saturating.
// Latency: 1 cycle; an op accepted at edge N presents its result from edge N until the output handshake completes.
// Backpressure: one-deep output register; in_ready = !out_valid || out_ready, so a stalled output stalls the input.
module accu_mc #(
    parameter int  IN_W     = 8,
    parameter int  ACC_W    = 16,
    parameter int  CHANNELS = 4,
    localparam int CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [1:0]          in_op,
    input  logic                in_sat,
    input  logic [IN_W-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_ch,
    output logic [ACC_W-1:0]    out_data,
    output logic                out_ovf,
    output logic [CHANNELS-1:0] ovf_sticky
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    logic [ACC_W-1:0]    acc [CHANNELS];
    logic                accept;
    logic                ch_ok;
    op_e                 op;
    logic [ACC_W-1:0]    a;
    logic [ACC_W-1:0]    d_ext;
    logic [ACC_W:0]      sum;
    logic [ACC_W:0]      diff;
    logic [ACC_W-1:0]    result;
    logic                ovf;
    logic [CHANNELS-1:0] sticky_nxt;

    // The output register can take a new result when empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op       = op_e'(in_op);
    assign d_ext    = ACC_W'(in_data);

    // Channel numbers beyond CHANNELS exist only for non-power-of-two counts; they touch no state.
    assign ch_ok = ({1'b0, in_ch} < (CH_W + 1)'(CHANNELS));

    // Read the addressed accumulator; an unmapped channel reads as zero.
    always_comb begin
        a = '0;
        if (ch_ok) begin
            a = acc[in_ch];
        end
    end

    // Compute the op result and its overflow/underflow flag.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, d_ext};
        diff   = {1'b0, a} - {1'b0, d_ext};
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                ovf    = sum[ACC_W];
                result = (ovf && in_sat) ? '1 : sum[ACC_W-1:0];
            end
            OP_SUB: begin
                // The extra top bit of the difference is the borrow.
                ovf    = diff[ACC_W];
                result = (ovf && in_sat) ? '0 : diff[ACC_W-1:0];
            end
            OP_LOAD: begin
                result = d_ext;
            end
            default: begin
                result = '0;
            end
        endcase
        if (!ch_ok) begin
            result = '0;
            ovf    = 1'b0;
        end
    end

    // Next sticky flags: CLEAR wipes the channel's flag, any overflow sets it.
    always_comb begin
        sticky_nxt = ovf_sticky;
        if (accept && ch_ok) begin
            if (op == OP_CLEAR) begin
                sticky_nxt[in_ch] = 1'b0;
            end
            if (ovf) begin
                sticky_nxt[in_ch] = 1'b1;
            end
        end
    end

    // Accumulators are written at accept so back-to-back ops on one channel chain without stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
        end else if (accept && ch_ok) begin
            acc[in_ch] <= result;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= '0;
        end else begin
            ovf_sticky <= sticky_nxt;
        end
    end

    // Output stage: reload on accept, drop valid after a handshake with no new accept, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= result;
            out_ovf   <= ovf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
